shift_register_seq: RTL and testbench
=====================================

Name: shift_register_seq

Overview:
Parametrised successor to the team's 8-bit parallel register. It holds a WIDTH-bit word with a vector parallel load and single-cycle shift, rotate, arithmetic-shift and clear operations. It also has a multi-step sequencer that applies a shift or rotate N times, one step per clock, with a busy/done handshake. It is used as the general-purpose data register and barrel-shift substitute in lab datapaths.

Parameters:
WIDTH, 8, register width in bits (>=2)
AMOUNT_W, 4, width of the step-count input; must satisfy 2^AMOUNT_W-1 >= WIDTH

Ports:
Clk  input  1  rising-edge clock, single clock domain
reset  input  1  asynchronous, active-high reset
P  input  WIDTH  parallel load data
mode  input  3  000 hold, 001 load, 010 shl, 011 shr, 100 rol, 101 ror, 110 asr, 111 clear
en  input  1  execute mode once at this edge (idle only)
start  input  1  launch multi-step sequence (idle only)
amount  input  AMOUNT_W  number of steps for start
ser_in_l  input  1  bit shifted into MSB on shr
ser_in_r  input  1  bit shifted into LSB on shl
Q  output  WIDTH  register contents
ser_out_l  output  1  Q[WIDTH-1], combinational from Q
ser_out_r  output  1  Q[0], combinational from Q
busy  output  1  sequence in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset is asynchronous and active-high. Clk is the only clock. Reset forces Q=0, busy=0, done=0, state=IDLE and internal count=0 immediately, without waiting for an edge.
- Per-step operations:
  - shl: Q <= {Q[W-2:0], ser_in_r}
  - shr: Q <= {ser_in_l, Q[W-1:1]}
  - rol: Q <= {Q[W-2:0], Q[W-1]}
  - ror: Q <= {Q[0], Q[W-1:1]}
  - asr: Q <= {Q[W-1], Q[W-1:1]}
  - load: Q <= P
  - clear: Q <= 0
  - hold: Q unchanged
- FSM has two states, IDLE and RUN. done is registered and is 0 in every cycle except the completion pulse.
- IDLE, start=1 (start has priority over en):
  - mode in {010..110} and amount!=0: latch mode and amount, go to RUN, busy<=1. Q is unchanged at this edge.
  - amount==0 with a shift-class mode: stay IDLE, Q unchanged, done<=1 for one cycle.
  - mode in {000, 001, 111}: execute that op once at this edge, stay IDLE, done<=1 for one cycle.
- IDLE, start=0, en=1: execute mode once at this edge. done stays 0.
- IDLE, start=0, en=0: hold.
- RUN:
  - Each edge applies one step of the latched mode and decrements the count.
  - ser_in_l and ser_in_r are sampled live at each step.
  - On the edge that applies the last step: state<=IDLE, busy<=0, done<=1.
  - Latency: start sampled at edge k → Q holds N steps, busy=0 and done=1 after edge k+N. done drops after edge k+N+1.
  - While RUN, en, start, mode, P and amount are ignored.
  - A new start may be sampled on the edge where done is high, since the FSM is already IDLE. done then clears and the new sequence begins normally.
- amount > WIDTH is legal: shifts continue to fill with serial input, rotates wrap modulo WIDTH naturally.
- Reset mid-RUN aborts the sequence: Q=0, busy=0, and no done pulse is produced.
- ser_out_l and ser_out_r track Q with no additional latency.

Test Plan:
1. Assert reset between clock edges with Q=0x5A and busy=1 → Q=0x00, busy=0, done=0 immediately; values persist while reset is high.
2. WIDTH=8, P=0xA5, mode=001, en=1 for one edge → Q=0xA5, done=0. Then en=0 for 3 edges → Q stays 0xA5. Then mode=111, en=1 → Q=0x00.
3. Q=0xA5, mode=101 (ror), amount=3, start pulse → busy=1 for 3 cycles, Q=0xD2, 0x69, 0xB4 after successive edges. done=1 for exactly one cycle alongside Q=0xB4. Toggling en and start during busy has no effect.
4. Q=0x81, mode=110 (asr), amount=2 → Q=0xC0, then 0xE0; done pulse. Q=0x81, mode=010 (shl), ser_in_r=1, amount=9 → Q=0xFF after step 8 and after step 9. Total latency 9 edges after the start edge.
5. Q=0x3C, start with amount=0, mode=011 → Q stays 0x3C, busy never asserts, done=1 in the next cycle. start with mode=001, P=0x77 → Q=0x77 and done=1 after one edge.
6. Q=0x01, mode=100 (rol), amount=5, start; assert reset after 2 steps (Q=0x04) → Q=0x00, busy=0, and no done pulse follows. A fresh start after reset release behaves normally.

Source files
------------

// File: rtl/shift_register_seq_if.sv
// Bus bundle for shift_register_seq: control, parallel/serial data in, register state out.
// The master side drives commands; the slave side is the register itself.
interface shift_register_seq_if #(
  parameter int WIDTH    = 8,
  parameter int AMOUNT_W = 4
);
  logic [WIDTH-1:0]    P;
  logic [2:0]          mode;
  logic                en;
  logic                start;
  logic [AMOUNT_W-1:0] amount;
  logic                ser_in_l;
  logic                ser_in_r;
  logic [WIDTH-1:0]    Q;
  logic                ser_out_l;
  logic                ser_out_r;
  logic                busy;
  logic                done;

  modport master (
    output P, mode, en, start, amount, ser_in_l, ser_in_r,
    input  Q, ser_out_l, ser_out_r, busy, done
  );

  modport slave (
    input  P, mode, en, start, amount, ser_in_l, ser_in_r,
    output Q, ser_out_l, ser_out_r, busy, done
  );
endinterface

// File: rtl/shift_register_seq.sv
// WIDTH-bit data register with single-cycle load/shift/rotate/clear and a
// sequencer that repeats a shift-class operation N times with busy/done.
module shift_register_seq #(
  parameter int WIDTH    = 8,
  parameter int AMOUNT_W = 4
) (
  input  logic                 Clk,
  input  logic                 reset,
  shift_register_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHL   = 3'b010,
    OP_SHR   = 3'b011,
    OP_ROL   = 3'b100,
    OP_ROR   = 3'b101,
    OP_ASR   = 3'b110,
    OP_CLEAR = 3'b111
  } op_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_next;
  logic [WIDTH-1:0]    q_reg, q_next;
  logic [AMOUNT_W-1:0] count, count_next;
  op_t                 op_reg, op_next;
  logic                done_reg, done_next;
  logic                shift_class;

  function automatic logic [WIDTH-1:0] apply_op(
    input op_t              op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] load,
    input logic             in_l,
    input logic             in_r
  );
    logic [WIDTH-1:0] res;
    res = cur;
    case (op)
      OP_HOLD:  res = cur;
      OP_LOAD:  res = load;
      OP_SHL:   res = {cur[WIDTH-2:0], in_r};
      OP_SHR:   res = {in_l, cur[WIDTH-1:1]};
      OP_ROL:   res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      OP_ROR:   res = {cur[0], cur[WIDTH-1:1]};
      OP_ASR:   res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      OP_CLEAR: res = '0;
      default:  res = cur;
    endcase
    return res;
  endfunction

  assign shift_class = (bus.mode >= 3'b010) && (bus.mode <= 3'b110);

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      q_reg    <= '0;
      count    <= '0;
      op_reg   <= OP_HOLD;
      done_reg <= 1'b0;
    end else begin
      state    <= state_next;
      q_reg    <= q_next;
      count    <= count_next;
      op_reg   <= op_next;
      done_reg <= done_next;
    end
  end

  // In RUN every command input is ignored; only the live serial inputs matter.
  always_comb begin
    state_next = state;
    q_next     = q_reg;
    count_next = count;
    op_next    = op_reg;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (shift_class) begin
            if (bus.amount != '0) begin
              op_next    = op_t'(bus.mode);
              count_next = bus.amount;
              state_next = RUN;
            end else begin
              done_next = 1'b1;
            end
          end else begin
            q_next    = apply_op(op_t'(bus.mode), q_reg, bus.P, bus.ser_in_l, bus.ser_in_r);
            done_next = 1'b1;
          end
        end else if (bus.en) begin
          q_next = apply_op(op_t'(bus.mode), q_reg, bus.P, bus.ser_in_l, bus.ser_in_r);
        end
      end
      RUN: begin
        q_next     = apply_op(op_reg, q_reg, bus.P, bus.ser_in_l, bus.ser_in_r);
        count_next = count - AMOUNT_W'(1);
        if (count == AMOUNT_W'(1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.Q         = q_reg;
  assign bus.ser_out_l = q_reg[WIDTH-1];
  assign bus.ser_out_r = q_reg[0];
  assign bus.busy      = (state == RUN);
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_shift_register_seq.sv
// Self-checking bench for shift_register_seq: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against an arithmetic model.
module tb_shift_register_seq;
  localparam int WIDTH    = 8;
  localparam int AMOUNT_W = 4;
  localparam int SPAN     = 1 << WIDTH;

  logic Clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic compare_on = 1'b0;

  shift_register_seq_if #(.WIDTH(WIDTH), .AMOUNT_W(AMOUNT_W)) bus ();

  shift_register_seq #(.WIDTH(WIDTH), .AMOUNT_W(AMOUNT_W)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Reference model: register value as an integer, remaining steps as a plain count.
  int       m_q    = 0;
  int       m_left = 0;
  int       m_mode = 0;
  logic     m_busy = 1'b0;
  logic     m_done = 1'b0;

  function automatic int stepOp(int m, int v, int p, int sl, int sr);
    case (m)
      0:       return v;
      1:       return p;
      2:       return (v * 2 + sr) % SPAN;
      3:       return v / 2 + sl * (SPAN / 2);
      4:       return (v * 2) % SPAN + v / (SPAN / 2);
      5:       return v / 2 + (v % 2) * (SPAN / 2);
      6:       return v / 2 + ((v >= SPAN / 2) ? SPAN / 2 : 0);
      default: return 0;
    endcase
  endfunction

  always @(posedge Clk or posedge reset) begin
    if (reset) begin
      m_q = 0; m_left = 0; m_busy = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_q = stepOp(m_mode, m_q, int'(bus.P), int'(bus.ser_in_l), int'(bus.ser_in_r));
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (bus.start) begin
        if (bus.mode >= 3'd2 && bus.mode <= 3'd6) begin
          if (bus.amount != 0) begin
            m_mode = int'(bus.mode);
            m_left = int'(bus.amount);
            m_busy = 1'b1;
          end else begin
            m_done = 1'b1;
          end
        end else begin
          m_q = stepOp(int'(bus.mode), m_q, int'(bus.P), int'(bus.ser_in_l), int'(bus.ser_in_r));
          m_done = 1'b1;
        end
      end else if (bus.en) begin
        m_q = stepOp(int'(bus.mode), m_q, int'(bus.P), int'(bus.ser_in_l), int'(bus.ser_in_r));
      end
    end
  end

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp_q, input logic exp_busy, input logic exp_done);
    checkVal({name, ".q"},    32'(bus.Q),    32'(exp_q));
    checkVal({name, ".busy"}, 32'(bus.busy), 32'(exp_busy));
    checkVal({name, ".done"}, 32'(bus.done), 32'(exp_done));
  endtask

  always @(negedge Clk) begin
    if (compare_on) begin
      checkVal("model.q",     32'(bus.Q),         32'(m_q));
      checkVal("model.busy",  32'(bus.busy),      32'(m_busy));
      checkVal("model.done",  32'(bus.done),      32'(m_done));
      checkVal("model.out_l", 32'(bus.ser_out_l), 32'(m_q / (SPAN / 2)));
      checkVal("model.out_r", 32'(bus.ser_out_r), 32'(m_q % 2));
    end
  end

  task automatic applyStimulus(input logic [2:0] m, input logic e, input logic s,
                               input logic [3:0] a, input logic [7:0] p,
                               input logic sl, input logic sr);
    bus.mode = m; bus.en = e; bus.start = s; bus.amount = a;
    bus.P = p; bus.ser_in_l = sl; bus.ser_in_r = sr;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge Clk);
  endtask

  task automatic idle();
    applyStimulus(3'b000, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic loadQ(input logic [7:0] v);
    applyStimulus(3'b001, 1'b1, 1'b0, 4'd0, v, 1'b0, 1'b0);
    tick();
    idle();
  endtask

  initial begin
    idle();
    #1 reset = 1'b1;
    tick(2);
    reset = 1'b0;
    compare_on = 1'b1;
    checkOutput("after_reset", 8'h00, 1'b0, 1'b0);

    // Async reset between edges while a sequence is running.
    loadQ(8'h5A);
    applyStimulus(3'b100, 1'b0, 1'b1, 4'd8, 8'h00, 1'b0, 1'b0);
    tick();
    idle();
    checkOutput("pre_reset", 8'h5A, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 checkOutput("reset_immediate", 8'h00, 1'b0, 1'b0);
    tick(2);
    checkOutput("reset_held", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    tick();

    // Load, hold, clear.
    applyStimulus(3'b001, 1'b1, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0);
    tick();
    checkOutput("load", 8'hA5, 1'b0, 1'b0);
    idle();
    tick(3);
    checkOutput("hold", 8'hA5, 1'b0, 1'b0);
    applyStimulus(3'b111, 1'b1, 1'b0, 4'd0, 8'hFF, 1'b0, 1'b0);
    tick();
    checkOutput("clear", 8'h00, 1'b0, 1'b0);

    // ror x3 with garbage commands during RUN.
    loadQ(8'hA5);
    applyStimulus(3'b101, 1'b0, 1'b1, 4'd3, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("ror_start", 8'hA5, 1'b1, 1'b0);
    applyStimulus(3'b111, 1'b1, 1'b1, 4'd7, 8'h33, 1'b1, 1'b1);
    tick();
    checkOutput("ror_1", 8'hD2, 1'b1, 1'b0);
    tick();
    checkOutput("ror_2", 8'h69, 1'b1, 1'b0);
    tick();
    checkOutput("ror_3", 8'hB4, 1'b0, 1'b1);
    idle();
    tick();
    checkOutput("ror_after", 8'hB4, 1'b0, 1'b0);

    // asr x2, then shl x9 with ones shifted in.
    loadQ(8'h81);
    applyStimulus(3'b110, 1'b0, 1'b1, 4'd2, 8'h00, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    checkOutput("asr_1", 8'hC0, 1'b1, 1'b0);
    tick();
    checkOutput("asr_2", 8'hE0, 1'b0, 1'b1);
    loadQ(8'h81);
    applyStimulus(3'b010, 1'b0, 1'b1, 4'd9, 8'h00, 1'b0, 1'b1);
    tick();
    applyStimulus(3'b000, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
    tick(8);
    checkOutput("shl_8", 8'hFF, 1'b1, 1'b0);
    tick();
    checkOutput("shl_9", 8'hFF, 1'b0, 1'b1);
    idle();
    tick();

    // amount==0 shift, then a load via start on the done cycle.
    loadQ(8'h3C);
    applyStimulus(3'b011, 1'b0, 1'b1, 4'd0, 8'h00, 1'b1, 1'b1);
    tick();
    checkOutput("zero_amount", 8'h3C, 1'b0, 1'b1);
    applyStimulus(3'b001, 1'b0, 1'b1, 4'd0, 8'h77, 1'b0, 1'b0);
    tick();
    checkOutput("start_load", 8'h77, 1'b0, 1'b1);
    idle();
    tick();
    checkOutput("start_load_after", 8'h77, 1'b0, 1'b0);

    // Reset aborts a rol sequence; no done afterwards.
    loadQ(8'h01);
    applyStimulus(3'b100, 1'b0, 1'b1, 4'd5, 8'h00, 1'b0, 1'b0);
    tick();
    idle();
    tick(2);
    checkOutput("rol_2", 8'h04, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 checkOutput("abort", 8'h00, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("abort_no_done_1", 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("abort_no_done_2", 8'h00, 1'b0, 1'b0);
    loadQ(8'h01);
    applyStimulus(3'b100, 1'b0, 1'b1, 4'd2, 8'h00, 1'b0, 1'b0);
    tick();
    idle();
    tick(2);
    checkOutput("fresh_rol", 8'h04, 1'b0, 1'b1);

    // Randomized traffic with occasional mid-cycle resets.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                    8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 79) == 0) begin
        #2 reset = 1'b1;
        @(negedge Clk);
        #2 reset = 1'b0;
        @(negedge Clk);
      end else begin
        tick();
      end
    end

    compare_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
